// File: rtl/cfu_requant_packer.sv
// Output stage for the codebook-MAC CFU: requantizes 32-bit accumulators to int8
// (bias, Q31 multiply, rounding shift, zero point, clamp) and packs bytes little-endian
// into 32-bit words. Three arithmetic stages feed a packer and one output register;
// everything stalls together when the output is backpressured.
module cfu_requant_packer #(
  parameter int unsigned PACK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_bias,
  input  logic [31:0] cfg_mult,
  input  logic [4:0]  cfg_shift,
  input  logic [7:0]  cfg_out_zp,
  input  logic [7:0]  cfg_act_min,
  input  logic [7:0]  cfg_act_max,
  input  logic        acc_valid,
  output logic        acc_ready,
  input  logic [31:0] acc_data,
  input  logic        acc_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_count,
  output logic        out_last
);

  // Latched configuration
  logic signed [31:0] bias_q, mult_q;
  logic [4:0]         shift_q;
  logic [7:0]         zp_q, min_q, max_q;

  // Pipeline stages
  logic               s1_valid_q, s1_last_q;
  logic signed [31:0] s1_b_q;
  logic               s2_valid_q, s2_last_q;
  logic signed [31:0] s2_x_q;
  logic               s3_valid_q, s3_last_q;
  logic [7:0]         s3_byte_q;

  // Packer and output register
  logic [2:0]         cnt_q;
  logic [31:0]        part_q;
  logic               out_valid_q, out_last_q;
  logic [31:0]        out_data_q;
  logic [2:0]         out_count_q;

  logic adv, cfg_fire, acc_fire;

  // Global advance, handshakes and drain detection
  always_comb begin
    adv       = !out_valid_q || out_ready;
    cfg_ready = !s1_valid_q && !s2_valid_q && !s3_valid_q && (cnt_q == 3'd0) && !out_valid_q;
    cfg_fire  = cfg_valid && cfg_ready;
    acc_ready = adv && !cfg_fire;
    acc_fire  = acc_valid && acc_ready;
  end

  // S2 datapath: saturating rounding doubling high multiply
  logic signed [63:0] a64, m64, prod, nudge, sum;
  logic signed [31:0] s2_res;
  always_comb begin
    a64    = s1_b_q;
    m64    = mult_q;
    prod   = a64 * m64;
    nudge  = prod[63] ? -64'sd1073741823 : 64'sd1073741824;
    sum    = prod + nudge;
    // floor(sum / 2^31), then bump negatives with a remainder to truncate toward zero
    s2_res = sum[62:31] + {31'd0, (sum[63] && (sum[30:0] != 31'd0))};
    if (s1_b_q == 32'sh80000000 && mult_q == 32'sh80000000) begin
      s2_res = 32'sh7FFFFFFF;
    end
  end

  // S3 datapath: round-half-away shift, zero point, activation clamp
  logic [31:0]        mask, rem, thr;
  logic signed [31:0] x_sh, y;
  logic signed [32:0] z, zmin, zmax;
  logic [7:0]         s3_res;
  always_comb begin
    mask = (32'd1 << shift_q) - 32'd1;
    rem  = s2_x_q & mask;
    thr  = (mask >> 1) + {31'd0, s2_x_q[31]};
    x_sh = s2_x_q >>> shift_q;
    y    = x_sh + {31'd0, (rem > thr)};
    z    = {y[31], y} + {{25{zp_q[7]}}, zp_q};
    zmin = {{25{min_q[7]}}, min_q};
    zmax = {{25{max_q[7]}}, max_q};
    if (z < zmin)      s3_res = min_q;
    else if (z > zmax) s3_res = max_q;
    else               s3_res = z[7:0];
  end

  // Packer: drop the S3 byte into lane cnt_q, decide whether the word is complete
  logic [31:0] merged;
  logic        emit;
  always_comb begin
    merged = part_q;
    for (int k = 0; k < PACK; k++) begin
      if (int'(cnt_q) == k) merged[8*k +: 8] = s3_byte_q;
    end
    emit = s3_valid_q && ((cnt_q == 3'(PACK - 1)) || s3_last_q);
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q  <= '0;
      mult_q  <= 32'sh7FFFFFFF;
      shift_q <= '0;
      zp_q    <= '0;
      min_q   <= 8'h80;
      max_q   <= 8'h7F;
    end else if (cfg_fire) begin
      bias_q  <= cfg_bias;
      mult_q  <= cfg_mult;
      shift_q <= cfg_shift;
      zp_q    <= cfg_out_zp;
      min_q   <= cfg_act_min;
      max_q   <= cfg_act_max;
    end
  end

  // Pipeline, packer and output register, all gated by adv
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_x_q      <= '0;
      s3_valid_q  <= 1'b0;
      s3_last_q   <= 1'b0;
      s3_byte_q   <= '0;
      cnt_q       <= '0;
      part_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= acc_fire;
      s1_last_q  <= acc_last;
      s1_b_q     <= acc_data + bias_q;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_x_q     <= s2_res;
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_byte_q  <= s3_res;
      out_valid_q <= emit;
      if (emit) begin
        out_data_q  <= merged;
        out_count_q <= cnt_q + 3'd1;
        out_last_q  <= s3_last_q;
        cnt_q       <= '0;
        part_q      <= '0;
      end else if (s3_valid_q) begin
        cnt_q  <= cnt_q + 3'd1;
        part_q <= merged;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_cfu_requant_packer.sv
// Directed bench for cfu_requant_packer: single-element vector table plus
// hand-written multi-cycle sequences (latency, backpressure, config, reset).
module tb_cfu_requant_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_bias, cfg_mult;
  logic [4:0]  cfg_shift;
  logic [7:0]  cfg_out_zp, cfg_act_min, cfg_act_max;
  logic        acc_valid, acc_ready, acc_last;
  logic [31:0] acc_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  cfu_requant_packer #(.PACK(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_bias   (cfg_bias),
    .cfg_mult   (cfg_mult),
    .cfg_shift  (cfg_shift),
    .cfg_out_zp (cfg_out_zp),
    .cfg_act_min(cfg_act_min),
    .cfg_act_max(cfg_act_max),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_last   (acc_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Received words, recorded in the cycle they are handshaked
  logic [31:0] q_data[$];
  logic [2:0]  q_count[$];
  logic        q_last[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_count.push_back(out_count);
      q_last.push_back(out_last);
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [31:0] bias;
    logic [31:0] mult;
    logic [4:0]  shift;
    logic [7:0]  zp;
    logic [7:0]  amin;
    logic [7:0]  amax;
    logic [31:0] acc;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_cfg(input logic [31:0] b, input logic [31:0] m, input logic [4:0] s,
                        input logic [7:0] zp, input logic [7:0] mn, input logic [7:0] mx);
    int  n = 0;
    bit  done = 0;
    cfg_bias = b; cfg_mult = m; cfg_shift = s;
    cfg_out_zp = zp; cfg_act_min = mn; cfg_act_max = mx;
    cfg_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (cfg_ready) done = 1;
      @(posedge clk); #1;
      n++;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL cfg_timeout: cfg_ready never rose within 200 cycles");
    end
  endtask

  task automatic send_acc(input logic [31:0] d, input logic l);
    int n = 0;
    bit done = 0;
    acc_data = d; acc_last = l; acc_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      if (acc_ready) begin
        hs_cyc = cyc;
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    acc_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL acc_timeout: acc_ready never rose within 200 cycles");
    end
  endtask

  task automatic expect_word(input string name, input logic [31:0] d, input logic [2:0] c,
                             input logic l, output int rcyc);
    int n = 0;
    rcyc = -1;
    while (q_data.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_data.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: got no output word, expected one within 200 cycles", name);
    end else begin
      check({name, "_data"}, q_data.pop_front(), d);
      check({name, "_count"}, 32'(q_count.pop_front()), 32'(c));
      check({name, "_last"}, 32'(q_last.pop_front()), 32'(l));
      rcyc = q_cyc.pop_front();
    end
  endtask

  task automatic clear_queues();
    q_data.delete(); q_count.delete(); q_last.delete(); q_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    logic [31:0] held;
    bit have_held;

    //             bias          mult          sh     zp     min    max    acc           byte
    vecs[0]  = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h00, 8'h80, 8'h7F, 32'd100,      8'h64};
    vecs[1]  = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h00, 8'h80, 8'h7F, 32'hFFFFFFFB, 8'hFB};
    vecs[2]  = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h00, 8'h80, 8'h7F, 32'd200,      8'h7F};
    vecs[3]  = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h00, 8'h80, 8'h7F, 32'hFFFFFC18, 8'h80};
    vecs[4]  = '{32'd0,        32'h80000000, 5'd0,  8'h00, 8'h80, 8'h7F, 32'h80000000, 8'h7F};
    vecs[5]  = '{32'd1,        32'h7FFFFFFF, 5'd0,  8'h00, 8'h80, 8'h7F, 32'h7FFFFFFF, 8'h80};
    vecs[6]  = '{32'd10,       32'h40000000, 5'd1,  8'hFD, 8'h80, 8'h7F, 32'd90,       8'h16};
    vecs[7]  = '{32'd10,       32'h40000000, 5'd1,  8'hFD, 8'h80, 8'h7F, 32'd91,       8'h17};
    vecs[8]  = '{32'd10,       32'h40000000, 5'd1,  8'hFD, 8'h80, 8'h7F, 32'hFFFFFFCE, 8'hF3};
    vecs[9]  = '{32'd0,        32'h7FFFFFFF, 5'd2,  8'h00, 8'h80, 8'h7F, 32'd6,        8'h02};
    vecs[10] = '{32'd0,        32'h7FFFFFFF, 5'd2,  8'h00, 8'h80, 8'h7F, 32'hFFFFFFFA, 8'hFE};
    vecs[11] = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h05, 8'hF6, 8'h14, 32'd30,       8'h14};
    vecs[12] = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h05, 8'hF6, 8'h14, 32'hFFFFFF9C, 8'hF6};
    vecs[13] = '{32'd0,        32'h7FFFFFFF, 5'd0,  8'h05, 8'hF6, 8'h14, 32'd3,        8'h08};
    vecs[14] = '{32'd0,        32'h80000000, 5'd0,  8'h00, 8'h80, 8'h7F, 32'd50,       8'hCE};
    vecs[15] = '{32'd0,        32'h7FFFFFFF, 5'd31, 8'h07, 8'h80, 8'h7F, 32'd100,      8'h07};
    vecs[16] = '{32'd0,        32'h7FFFFFFF, 5'd31, 8'h07, 8'h80, 8'h7F, 32'hFFFFFF9C, 8'h07};
    vecs[17] = '{32'd0,        32'h40000000, 5'd0,  8'h00, 8'h80, 8'h7F, 32'd3,        8'h02};
    vecs[18] = '{32'd0,        32'h40000000, 5'd0,  8'h00, 8'h80, 8'h7F, 32'hFFFFFFFD, 8'hFF};

    reset = 1'b1;
    cfg_valid = 1'b0; cfg_bias = '0; cfg_mult = '0; cfg_shift = '0;
    cfg_out_zp = '0; cfg_act_min = '0; cfg_act_max = '0;
    acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_acc_ready", 32'(acc_ready), 32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;

    // Reset-default config, full word, latency
    send_acc(32'd100, 1'b0);
    send_acc(32'hFFFFFFFB, 1'b0);
    send_acc(32'd127, 1'b0);
    send_acc(32'd200, 1'b1);
    expect_word("defaults", 32'h7F7FFB64, 3'd4, 1'b1, rc);
    check("latency", 32'(rc), 32'(hs_cyc + 4));

    // Table of single-element groups
    for (int i = 0; i < 19; i++) begin
      do_cfg(vecs[i].bias, vecs[i].mult, vecs[i].shift, vecs[i].zp, vecs[i].amin, vecs[i].amax);
      send_acc(vecs[i].acc, 1'b1);
      expect_word($sformatf("vec%0d", i), {24'd0, vecs[i].exp_byte}, 3'd1, 1'b1, rc);
    end

    // Partial word forced by last
    do_cfg(32'd10, 32'h40000000, 5'd1, 8'hFD, 8'h80, 8'h7F);
    send_acc(32'd90, 1'b0);
    send_acc(32'd91, 1'b0);
    send_acc(32'hFFFFFFCE, 1'b1);
    expect_word("partial", 32'h00F31716, 3'd3, 1'b1, rc);

    // Backpressure mid-stream
    do_cfg(32'd0, 32'h7FFFFFFF, 5'd0, 8'h00, 8'h80, 8'h7F);
    have_held = 0;
    held = '0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_acc(32'(i * 10 - 50), (i == 11));
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          if (out_valid) begin
            if (!have_held) begin
              held = out_data;
              have_held = 1;
            end else begin
              check("stall_hold", out_data, held);
            end
            check("stall_acc_ready", 32'(acc_ready), 32'd0);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stall_seen", 32'(have_held), 32'd1);
    expect_word("bp_w0", 32'hECE2D8CE, 3'd4, 1'b0, rc);
    expect_word("bp_w1", 32'h140A00F6, 3'd4, 1'b0, rc);
    expect_word("bp_w2", 32'h3C32281E, 3'd4, 1'b1, rc);

    // Config raised while busy waits for drain
    send_acc(32'd1, 1'b0);
    send_acc(32'd2, 1'b0);
    cfg_bias = 32'd0; cfg_mult = 32'h7FFFFFFF; cfg_shift = 5'd0;
    cfg_out_zp = 8'd10; cfg_act_min = 8'h80; cfg_act_max = 8'h7F;
    cfg_valid = 1'b1;
    send_acc(32'd3, 1'b1);
    @(negedge clk);
    check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    @(posedge clk); #1;
    do_cfg(32'd0, 32'h7FFFFFFF, 5'd0, 8'd10, 8'h80, 8'h7F);
    check("cfg_after_drain", 32'(q_data.size()), 32'd1);
    send_acc(32'd4, 1'b1);
    expect_word("pre_cfg", 32'h00030201, 3'd3, 1'b1, rc);
    expect_word("post_cfg", 32'h0000000E, 3'd1, 1'b1, rc);

    // Simultaneous config and acc when idle: config wins
    cfg_bias = 32'd0; cfg_mult = 32'h7FFFFFFF; cfg_shift = 5'd0;
    cfg_out_zp = 8'd0; cfg_act_min = 8'h80; cfg_act_max = 8'h7F;
    cfg_valid = 1'b1;
    acc_data = 32'd55; acc_last = 1'b1; acc_valid = 1'b1;
    @(negedge clk);
    check("simul_acc_ready", 32'(acc_ready), 32'd0);
    check("simul_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("simul_acc_next", 32'(acc_ready), 32'd1);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    expect_word("simul", 32'h00000037, 3'd1, 1'b1, rc);

    // Reset with 2 bytes in the packer and 2 entries in flight
    do_cfg(32'd0, 32'h7FFFFFFF, 5'd0, 8'd20, 8'h80, 8'h7F);
    send_acc(32'd10, 1'b0);
    send_acc(32'd11, 1'b0);
    send_acc(32'd12, 1'b0);
    send_acc(32'd13, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_queues();
    @(negedge clk);
    check("rst2_acc_ready", 32'(acc_ready), 32'd1);
    check("rst2_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (6) begin
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    send_acc(32'd1, 1'b0);
    send_acc(32'd2, 1'b0);
    send_acc(32'd3, 1'b0);
    send_acc(32'd4, 1'b0);
    expect_word("post_reset", 32'h04030201, 3'd4, 1'b0, rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
